reg_swap_scheduler: RTL

REG_SWAP_SCHEDULER -- requirements
Module: reg_swap_scheduler

---
 rtl/reg_swap_scheduler_pkg.sv | 9 +
 rtl/rr_arb2.sv | 14 +
 rtl/reg_swap_scheduler.sv | 82 ++++++++
 3 files changed

// File: rtl/reg_swap_scheduler_pkg.sv
// reg_swap_scheduler_pkg: shared state encoding, default sizes and index range helper.
package reg_swap_scheduler_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;
    function automatic logic in_range(input int idx, input int depth);
        return idx < depth;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer moves to the loser on every accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    logic ptr;
    always_comb gnt = &req ? (ptr ? 2'b10 : 2'b01) : req;
    always_ff @(posedge clk)
        if (rst) ptr <= 1'b0;
        else if (accept) ptr <= gnt[0];
endmodule

// File: rtl/reg_swap_scheduler.sv
// reg_swap_scheduler: register file whose entries two requesters can exchange
// through an IDLE -> CAPTURE -> COMMIT sequence, plus a direct-load port.
module reg_swap_scheduler
    import reg_swap_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [2*IW-1:0]   req_idx_a,
    input  logic [2*IW-1:0]   req_idx_b,
    output logic [1:0]        req_gnt,
    output logic              swap_done,
    output logic              busy,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic [IW-1:0]     rd_idx,
    output logic [WIDTH-1:0]  rd_data
);
    state_t state, state_nx;
    logic [WIDTH-1:0] rf [DEPTH];
    logic [IW-1:0] idx_a, idx_b;
    logic [WIDTH-1:0] temp_a, temp_b;
    logic [1:0] arb_req;
    logic a_ok, b_ok;

    assign busy     = state != IDLE;
    assign wr_ready = ~busy;
    assign a_ok     = in_range(int'(idx_a), DEPTH);
    assign b_ok     = in_range(int'(idx_b), DEPTH);
    assign rd_data  = in_range(int'(rd_idx), DEPTH) ? rf[rd_idx] : '0;
    // Reset masks requests so neither a grant nor a pointer move can happen under rst.
    assign arb_req  = (state == IDLE && !rst) ? req_valid : 2'b00;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .accept (|req_gnt),
        .gnt    (req_gnt)
    );

    always_comb begin
        state_nx = IDLE;
        if (state == IDLE) state_nx = |arb_req ? CAPTURE : IDLE;
        else if (state == CAPTURE) state_nx = COMMIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx_a     <= '0;
            idx_b     <= '0;
            temp_a    <= '0;
            temp_b    <= '0;
            swap_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else begin
            state     <= state_nx;
            swap_done <= state == COMMIT;
            if (|req_gnt) begin
                idx_a <= req_gnt[1] ? req_idx_a[2*IW-1:IW] : req_idx_a[IW-1:0];
                idx_b <= req_gnt[1] ? req_idx_b[2*IW-1:IW] : req_idx_b[IW-1:0];
            end
            if (state == CAPTURE) begin
                temp_a <= a_ok ? rf[idx_a] : '0;
                temp_b <= b_ok ? rf[idx_b] : '0;
            end
            // Equal indices write the same value twice, leaving the entry unchanged.
            if (state == COMMIT && a_ok && b_ok) begin
                rf[idx_a] <= temp_b;
                rf[idx_b] <= temp_a;
            end
            if (wr_en && wr_ready && in_range(int'(wr_idx), DEPTH)) rf[wr_idx] <= wr_data;
        end
    end
endmodule
